// File: rtl/fetch_stage.sv
// IF stage of the 16-bit MIPS-like core: owns the PC, fetches from instr_mem and fills IF/ID.
// Handles stall, redirect flush and halting once the PC runs past the end of the ROM.
module fetch_stage #(
    parameter int PC_W      = 16,
    parameter int ROM_BYTES = 512,
    parameter int RESET_PC  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] imem_pc,
    input  logic [15:0]     imem_instr,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [15:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc,
    output logic [PC_W-1:0] if_id_pc_p2,
    output logic            halted,
    output logic            misalign_err,
    output logic [15:0]     fetch_cnt
);

    typedef enum logic [1:0] {
        BUBBLE = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } state_t;

    localparam logic [PC_W:0]   ROM_LIM = (PC_W+1)'(ROM_BYTES);
    localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_STEP = PC_W'(2);

    state_t          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] target;
    logic            target_in_rom;
    logic            pc_out_of_rom;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign imem_pc       = pc_q;
    assign target        = {redirect_pc[PC_W-1:1], 1'b0};
    assign target_in_rom = ({1'b0, target} < ROM_LIM);
    assign pc_out_of_rom = ({1'b0, pc_q} >= ROM_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= BUBBLE;
            pc_q         <= PC_RST;
            if_id_valid  <= 1'b0;
            if_id_instr  <= 16'h0000;
            if_id_pc     <= '0;
            if_id_pc_p2  <= '0;
            halted       <= 1'b0;
            misalign_err <= 1'b0;
            fetch_cnt    <= 16'h0000;
        end else begin
            case (state)
                BUBBLE: begin
                    state <= RUN;
                end
                RUN: begin
                    // Priority: redirect, then stall, then end-of-ROM, then normal fetch
                    if (redirect) begin
                        pc_q        <= target;
                        if_id_valid <= 1'b0;
                        if_id_instr <= 16'h0000;
                        if (redirect_pc[0])
                            misalign_err <= 1'b1;
                    end else if (stall) begin
                        pc_q <= pc_q;
                    end else if (pc_out_of_rom) begin
                        if_id_valid <= 1'b0;
                        if_id_instr <= 16'h0000;
                        halted      <= 1'b1;
                        state       <= HALT;
                    end else begin
                        if_id_instr <= imem_instr;
                        if_id_pc    <= pc_q;
                        if_id_pc_p2 <= pc_q + PC_STEP;
                        if_id_valid <= 1'b1;
                        pc_q        <= pc_q + PC_STEP;
                        fetch_cnt   <= sat_inc(fetch_cnt);
                    end
                end
                HALT: begin
                    // Only a redirect back into the ROM restarts fetch; stall has no effect here
                    if (redirect && target_in_rom) begin
                        pc_q        <= target;
                        if_id_valid <= 1'b0;
                        if_id_instr <= 16'h0000;
                        halted      <= 1'b0;
                        state       <= RUN;
                        if (redirect_pc[0])
                            misalign_err <= 1'b1;
                    end
                end
                default: begin
                    state <= BUBBLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic, all compared against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int PC_W = 16;
    localparam int ROM  = 512;

    logic            clk;
    logic            rst_n;
    logic [PC_W-1:0] imem_pc;
    logic [15:0]     imem_instr;
    logic            stall;
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;
    logic            if_id_valid;
    logic [15:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc;
    logic [PC_W-1:0] if_id_pc_p2;
    logic            halted;
    logic            misalign_err;
    logic [15:0]     fetch_cnt;

    logic [15:0] rom [0:255];

    int n_checks;
    int n_fails;

    // Reference model state: mode 0 = waiting out the post-reset bubble, 1 = fetching, 2 = halted
    int          m_mode;
    int          m_pc;
    bit          m_valid;
    logic [15:0] m_instr;
    int          m_ipc;
    int          m_cnt;
    bit          m_mis;
    bit          m_halted;

    fetch_stage #(.PC_W(PC_W), .ROM_BYTES(ROM), .RESET_PC(0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_pc      (imem_pc),
        .imem_instr   (imem_instr),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .if_id_valid  (if_id_valid),
        .if_id_instr  (if_id_instr),
        .if_id_pc     (if_id_pc),
        .if_id_pc_p2  (if_id_pc_p2),
        .halted       (halted),
        .misalign_err (misalign_err),
        .fetch_cnt    (fetch_cnt)
    );

    assign imem_instr = rom[imem_pc[8:1]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode   = 0;
        m_pc     = 0;
        m_valid  = 0;
        m_instr  = 16'h0000;
        m_ipc    = 0;
        m_cnt    = 0;
        m_mis    = 0;
        m_halted = 0;
    endtask

    task automatic model_edge();
        int tgt;
        tgt = int'(redirect_pc) & 32'hFFFE;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (redirect && tgt < ROM) begin
                m_pc     = tgt;
                m_mode   = 1;
                m_halted = 0;
                if (redirect_pc[0]) m_mis = 1;
            end
        end else if (redirect) begin
            m_pc    = tgt;
            m_valid = 0;
            m_instr = 16'h0000;
            if (redirect_pc[0]) m_mis = 1;
        end else if (stall) begin
            // everything holds
        end else if (m_pc >= ROM) begin
            m_valid  = 0;
            m_instr  = 16'h0000;
            m_mode   = 2;
            m_halted = 1;
        end else begin
            m_valid = 1;
            m_instr = rom[m_pc / 2];
            m_ipc   = m_pc;
            m_pc    = (m_pc + 2) % 65536;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic compare_all(input string t);
        check({t, ":imem_pc"}, 32'(imem_pc), 32'(m_pc));
        check({t, ":valid"}, 32'(if_id_valid), 32'(m_valid));
        check({t, ":instr"}, 32'(if_id_instr), 32'(m_instr));
        check({t, ":halted"}, 32'(halted), 32'(m_halted));
        check({t, ":misalign"}, 32'(misalign_err), 32'(m_mis));
        check({t, ":fetch_cnt"}, 32'(fetch_cnt), 32'(m_cnt));
        if (m_valid) begin
            check({t, ":if_id_pc"}, 32'(if_id_pc), 32'(m_ipc));
            check({t, ":if_id_pc_p2"}, 32'(if_id_pc_p2), 32'((m_ipc + 2) % 65536));
        end
    endtask

    // One clock: inputs are already set, model follows the edge, outputs sampled 1 time unit later
    task automatic cycle(input string t);
        @(posedge clk);
        model_edge();
        #1;
        compare_all(t);
    endtask

    task automatic set_in(input logic s, input logic r, input int tgt);
        stall       = s;
        redirect    = r;
        redirect_pc = PC_W'(tgt);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h2240;
        rom[1] = 16'h2485;

        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 0);
        model_reset();
        #1;
        compare_all("reset");
        check("reset:if_id_pc", 32'(if_id_pc), 32'h0);
        check("reset:if_id_pc_p2", 32'(if_id_pc_p2), 32'h0);
        #11 rst_n = 1'b1;

        // Bubble, then sequential fetch from 0
        cycle("t1_bubble");
        check("t1_bubble_valid", 32'(if_id_valid), 32'h0);
        cycle("t1_f0");
        check("t1_pc0", 32'(if_id_pc), 32'h0);
        check("t1_instr0", 32'(if_id_instr), 32'h2240);
        check("t1_cnt1", 32'(fetch_cnt), 32'h1);
        cycle("t1_f1");
        check("t1_pc2", 32'(if_id_pc), 32'h2);
        check("t1_instr1", 32'(if_id_instr), 32'h2485);
        check("t1_pc_p2", 32'(if_id_pc_p2), 32'h4);

        // Stall for three cycles while IF/ID holds pc 2
        set_in(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle("t2_stall");
            check("t2_hold_pc", 32'(if_id_pc), 32'h2);
            check("t2_hold_instr", 32'(if_id_instr), 32'h2485);
            check("t2_hold_imem", 32'(imem_pc), 32'h4);
        end
        set_in(1'b0, 1'b0, 0);
        cycle("t2_release");
        check("t2_next_pc", 32'(if_id_pc), 32'h4);

        // Redirect and stall together while imem_pc = 6
        check("t3_pre_imem", 32'(imem_pc), 32'h6);
        set_in(1'b1, 1'b1, 8);
        cycle("t3_redir");
        check("t3_flush", 32'(if_id_valid), 32'h0);
        check("t3_imem8", 32'(imem_pc), 32'h8);
        set_in(1'b0, 1'b0, 0);
        cycle("t3_after");
        check("t3_pc8", 32'(if_id_pc), 32'h8);

        // Odd redirect target
        set_in(1'b0, 1'b1, 9);
        cycle("t4_odd");
        check("t4_imem8", 32'(imem_pc), 32'h8);
        check("t4_misalign", 32'(misalign_err), 32'h1);
        set_in(1'b0, 1'b0, 0);

        // Free-run to the end of the ROM (bounded)
        for (int i = 0; i < 400 && !halted; i++) cycle("t5_run");
        check("t5_halted", 32'(halted), 32'h1);
        check("t5_imem512", 32'(imem_pc), 32'h200);
        check("t5_misalign_sticky", 32'(misalign_err), 32'h1);
        set_in(1'b1, 1'b0, 0);
        cycle("t5_stall_in_halt");
        set_in(1'b0, 1'b1, 600);
        cycle("t5_redir600");
        check("t5_still_halted", 32'(halted), 32'h1);
        set_in(1'b0, 1'b1, 0);
        cycle("t5_redir0");
        check("t5_unhalt", 32'(halted), 32'h0);
        check("t5_bubble", 32'(if_id_valid), 32'h0);
        set_in(1'b0, 1'b0, 0);
        cycle("t5_resume");
        check("t5_resume_pc", 32'(if_id_pc), 32'h0);
        check("t5_resume_valid", 32'(if_id_valid), 32'h1);

        // Asynchronous reset between edges while pc_q = 0x20
        set_in(1'b0, 1'b1, 32'h20);
        cycle("t6_redir");
        set_in(1'b1, 1'b0, 0);
        check("t6_pc20", 32'(imem_pc), 32'h20);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("t6_async");
        #2 rst_n = 1'b1;
        set_in(1'b0, 1'b0, 0);
        cycle("t6_bubble");
        check("t6_bubble_valid", 32'(if_id_valid), 32'h0);
        cycle("t6_first");
        check("t6_pc0", 32'(if_id_pc), 32'h0);

        // Randomized stall/redirect traffic, including odd and out-of-range targets
        for (int i = 0; i < 2000; i++) begin
            int r;
            int tgt;
            r   = int'($urandom_range(0, 99));
            tgt = int'($urandom_range(0, 700));
            set_in(r < 25, (r >= 20 && r < 30), tgt);
            cycle("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
